// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: size encodings, FSM states and the alignment rule shared by the LSU.
package load_store_unit_pkg;
  localparam int ADDR_W_DEF = 7;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_INV = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_e;
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] addr);
    return size == SZ_INV || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus the word-memory pins driven by the LSU.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(parameter int ADDR_W = ADDR_W_DEF);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_rw;
  logic [31:0]       mem_data_out;
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data_in, mem_rw
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data_in, mem_rw
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: extracts and extends the addressed lane for loads, merges store data into a word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_byte = i_word[{i_addr, 3'b000} +: 8];
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    o_rdata = i_size == SZ_BYTE ? {{24{w_byte[7] & ~i_unsigned}}, w_byte}
            : i_size == SZ_HALF ? {{16{w_half[15] & ~i_unsigned}}, w_half}
            : i_word;
    o_merged = i_size == SZ_WORD ? i_wdata : i_word;
    if (i_size == SZ_BYTE) o_merged[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
    if (i_size == SZ_HALF) o_merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word memory; sub-word stores are read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(parameter int ADDR_W = ADDR_W_DEF)
(
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);
  state_e            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_wdata;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_address;
  logic [31:0]       r_mem_data_in;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic [31:0]       w_rdata;
  logic [31:0]       w_merged;
  lsu_lane_align u_align (
    .i_word     (bus.mem_data_out),
    .i_addr     (r_addr_lo),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .o_rdata    (w_rdata),
    .o_merged   (w_merged)
  );
  assign bus.req_ready   = r_state == IDLE;
  assign bus.mem_rw      = r_mem_rw;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.resp_err    = r_resp_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mem_rw      <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      r_mem_rw     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_we      <= bus.req_we;
          r_size    <= bus.req_size;
          r_uns     <= bus.req_unsigned;
          r_addr_lo <= bus.req_addr[1:0];
          r_wdata   <= bus.req_wdata;
          if (bad_access(bus.req_size, bus.req_addr[1:0])) begin
            r_state      <= ERR;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else begin
            r_mem_address <= bus.req_addr[ADDR_W+1:2];
            if (bus.req_we && bus.req_size == SZ_WORD) begin
              r_state       <= WRITE;
              r_mem_rw      <= 1'b1;
              r_mem_data_in <= bus.req_wdata;
            end else r_state <= READ;
          end
        end
        // Memory read data is valid in this cycle; loads respond, sub-word stores write back the merge
        READ: if (r_we) begin
          r_state       <= WRITE;
          r_mem_rw      <= 1'b1;
          r_mem_data_in <= w_merged;
        end else begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_rdata;
        end
        WRITE: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a word-memory model with hand-computed expectations.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mem [128] = '{default: 32'h0};
  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_data_out = mem[bus.mem_address];
  always @(posedge clk) if (bus.mem_rw) mem[bus.mem_address] <= bus.mem_data_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [1:0] sz, input logic uns, input logic [8:0] a, input logic [31:0] wd);
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
  endtask
  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [8:0] a, input logic [31:0] wd, input int lat, input logic err,
                      input logic [31:0] rd, input int nrw, input logic [6:0] wa, input logic [31:0] wdat);
    int n_rw = 0;
    int got_lat = 0;
    int w_at = 0;
    logic [6:0] wr_a = '0;
    logic [31:0] wr_d = '0;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    drive(we, sz, uns, a, wd);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 6 && got_lat == 0; c++) begin
      if (c == 1) chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
      if (bus.mem_rw) begin
        n_rw++;
        w_at = c;
        wr_a = bus.mem_address;
        wr_d = bus.mem_data_in;
      end
      if (bus.resp_valid) begin
        got_lat = c;
        chk({tag, "_err"}, 32'(bus.resp_err), 32'(err));
        chk({tag, "_rdata"}, bus.resp_rdata, rd);
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, 32'(got_lat), 32'(lat));
    chk({tag, "_nrw"}, 32'(n_rw), 32'(nrw));
    if (nrw > 0) begin
      chk({tag, "_wcyc"}, 32'(w_at), 32'(lat - 1));
      chk({tag, "_waddr"}, 32'(wr_a), 32'(wa));
      chk({tag, "_wdata"}, wr_d, wdat);
    end
    chk({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_nopulse"}, 32'(bus.resp_valid), 32'd0);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 9'h010, 32'h12345678);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_rw", 32'(bus.mem_rw), 32'd0);
      chk("rst_resp", {bus.resp_valid, bus.resp_err, 30'd0}, 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'd0);
      chk("rst_addr", 32'(bus.mem_address), 32'd0);
      chk("rst_din", bus.mem_data_in, 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
    end
    chk("rst_nowrite", mem[4], 32'd0);
    rst_n = 1'b1;
    xact("st_w",   1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 2, 1'b0, 32'h0,        1, 7'd4, 32'hDEADBEEF);
    xact("ld_sb",  1'b0, 2'b00, 1'b0, 9'h013, 32'h0,        2, 1'b0, 32'hFFFFFFDE, 0, 7'd0, 32'h0);
    xact("ld_ub",  1'b0, 2'b00, 1'b1, 9'h013, 32'h0,        2, 1'b0, 32'h000000DE, 0, 7'd0, 32'h0);
    xact("ld_sh",  1'b0, 2'b01, 1'b0, 9'h012, 32'h0,        2, 1'b0, 32'hFFFFDEAD, 0, 7'd0, 32'h0);
    xact("ld_w",   1'b0, 2'b10, 1'b1, 9'h010, 32'h0,        2, 1'b0, 32'hDEADBEEF, 0, 7'd0, 32'h0);
    xact("st_b",   1'b1, 2'b00, 1'b0, 9'h011, 32'hFFFFFF55, 3, 1'b0, 32'h0,        1, 7'd4, 32'hDEAD55EF);
    xact("ld_w2",  1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        2, 1'b0, 32'hDEAD55EF, 0, 7'd0, 32'h0);
    xact("ld_uh0", 1'b0, 2'b01, 1'b1, 9'h010, 32'h0,        2, 1'b0, 32'h000055EF, 0, 7'd0, 32'h0);
    xact("ld_sb0", 1'b0, 2'b00, 1'b0, 9'h010, 32'h0,        2, 1'b0, 32'hFFFFFFEF, 0, 7'd0, 32'h0);
    xact("e_ldw",  1'b0, 2'b10, 1'b0, 9'h012, 32'h0,        1, 1'b1, 32'h0,        0, 7'd0, 32'h0);
    xact("e_sth",  1'b1, 2'b01, 1'b0, 9'h011, 32'h0000CAFE, 1, 1'b1, 32'h0,        0, 7'd0, 32'h0);
    xact("e_inv",  1'b1, 2'b11, 1'b0, 9'h010, 32'h11111111, 1, 1'b1, 32'h0,        0, 7'd0, 32'h0);
    chk("err_mem", mem[4], 32'hDEAD55EF);
    xact("st_h",   1'b1, 2'b01, 1'b0, 9'h01A, 32'hFFFF8001, 3, 1'b0, 32'h0,        1, 7'd6, 32'h80010000);
    xact("ld_sh6", 1'b0, 2'b01, 1'b0, 9'h01A, 32'h0,        2, 1'b0, 32'hFFFF8001, 0, 7'd0, 32'h0);
    xact("ld_uh6", 1'b0, 2'b01, 1'b1, 9'h01A, 32'h0,        2, 1'b0, 32'h00008001, 0, 7'd0, 32'h0);
    xact("st_top", 1'b1, 2'b10, 1'b0, 9'h1FC, 32'hA5A5A5A5, 2, 1'b0, 32'h0,        1, 7'd127, 32'hA5A5A5A5);
    xact("ld_top", 1'b0, 2'b00, 1'b1, 9'h1FF, 32'h0,        2, 1'b0, 32'h000000A5, 0, 7'd0, 32'h0);
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 9'h010, 32'h000000AA);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("rr_read_rw", 32'(bus.mem_rw), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rr_rw", 32'(bus.mem_rw), 32'd0);
    chk("rr_resp", 32'(bus.resp_valid), 32'd0);
    chk("rr_idle", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rr_resp2", 32'(bus.resp_valid), 32'd0);
    chk("rr_rw2", 32'(bus.mem_rw), 32'd0);
    xact("rr_ld",  1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        2, 1'b0, 32'hDEAD55EF, 0, 7'd0, 32'h0);
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 9'h014, 32'h00000077);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_wr", 32'(bus.mem_rw), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_resp", 32'(bus.resp_valid), 32'd0);
    chk("rw_rw", 32'(bus.mem_rw), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_resp2", 32'(bus.resp_valid), 32'd0);
    xact("rw_ld",  1'b0, 2'b10, 1'b0, 9'h014, 32'h0,        2, 1'b0, 32'h00000077, 0, 7'd0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
